// File: rtl/pmem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pmem_loader_if                                                 |
// | Brief   : UART byte stream in, program-memory write port and boot status |
// |           out, bundled for the pmem_loader block.                        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface pmem_loader_if #(
    parameter int PMEM_ADDR_WIDTH = 12
);
    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr;
    logic [31:0]                pmem_wr_data;
    logic [3:0]                 pmem_byte_w_en;
    logic                       cpu_rst;
    logic                       load_busy;
    logic                       load_err;

    // Byte source / memory-and-core side of the loader
    modport master (
        output rx_data, rx_valid,
        input  pmem_wr_addr, pmem_wr_data, pmem_byte_w_en,
        input  cpu_rst, load_busy, load_err
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output pmem_wr_addr, pmem_wr_data, pmem_byte_w_en,
        output cpu_rst, load_busy, load_err
    );
endinterface
`default_nettype wire

// File: rtl/pmem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pmem_loader                                                    |
// | Brief   : Frames a UART byte stream into 32-bit program words, writes    |
// |           them to program memory and releases the core on a good image. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pmem_loader #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  wire logic      sysclk,
    input  wire logic      rst,
    pmem_loader_if.slave   bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LEN_LO = 3'd1;
    localparam logic [2:0] c_ST_LEN_HI = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_CHECK  = 3'd4;
    localparam logic [2:0] c_ST_RUN    = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    localparam logic [7:0]  c_SOF      = 8'hA5;
    localparam int          c_TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] c_DEPTH    = 17'd1 << PMEM_ADDR_WIDTH;

    logic [2:0]                 r_state,    w_state;
    logic [15:0]                r_count,    w_count;
    logic [PMEM_ADDR_WIDTH-1:0] r_word_idx, w_word_idx;
    logic [1:0]                 r_byte_idx, w_byte_idx;
    logic [23:0]                r_word,     w_word;
    logic [7:0]                 r_xor,      w_xor;
    logic [c_TW-1:0]            r_timer,    w_timer;
    logic [PMEM_ADDR_WIDTH-1:0] r_wr_addr,  w_wr_addr;
    logic [31:0]                r_wr_data,  w_wr_data;
    logic [3:0]                 r_wr_en,    w_wr_en;
    logic                       r_cpu_rst,  w_cpu_rst;
    logic                       r_busy,     w_busy;
    logic                       r_err,      w_err;

    logic        w_sof;
    logic [15:0] w_len;
    logic        w_last;
    logic        w_in_frame;

    assign w_sof      = bus.rx_valid && (bus.rx_data == c_SOF);
    assign w_len      = {bus.rx_data, r_count[7:0]};
    // Word being completed is the final one of the image
    assign w_last     = ((17'(r_word_idx) + 17'd1) == {1'b0, r_count});
    assign w_in_frame = (r_state inside {c_ST_LEN_LO, c_ST_LEN_HI, c_ST_DATA, c_ST_CHECK});

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_xor      <= '0;
            r_timer    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= '0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_count    <= w_count;
            r_word_idx <= w_word_idx;
            r_byte_idx <= w_byte_idx;
            r_word     <= w_word;
            r_xor      <= w_xor;
            r_timer    <= w_timer;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_wr_en    <= w_wr_en;
            r_cpu_rst  <= w_cpu_rst;
            r_busy     <= w_busy;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_word_idx = r_word_idx;
        w_byte_idx = r_byte_idx;
        w_word     = r_word;
        w_xor      = r_xor;
        w_timer    = '0;
        w_wr_addr  = r_wr_addr;
        w_wr_data  = r_wr_data;
        w_wr_en    = 4'b0000;

        case (r_state)
            c_ST_IDLE, c_ST_RUN, c_ST_ERR: begin
                if (w_sof) begin
                    w_state    = c_ST_LEN_LO;
                    w_word_idx = '0;
                    w_byte_idx = '0;
                    w_xor      = '0;
                end
            end
            c_ST_LEN_LO: begin
                if (bus.rx_valid) begin
                    w_count[7:0] = bus.rx_data;
                    w_state      = c_ST_LEN_HI;
                end
            end
            c_ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    w_count[15:8] = bus.rx_data;
                    if (w_len == 16'd0) begin
                        w_state = c_ST_CHECK;
                    end else if ({1'b0, w_len} > c_DEPTH) begin
                        w_state = c_ST_ERR;
                    end else begin
                        w_state = c_ST_DATA;
                    end
                end
            end
            c_ST_DATA: begin
                if (bus.rx_valid) begin
                    w_xor      = r_xor ^ bus.rx_data;
                    w_byte_idx = r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0:    w_word[7:0]   = bus.rx_data;
                        2'd1:    w_word[15:8]  = bus.rx_data;
                        2'd2:    w_word[23:16] = bus.rx_data;
                        default: begin
                            // Byte 3 completes the word: issue the one-cycle write
                            w_wr_data  = {bus.rx_data, r_word};
                            w_wr_addr  = r_word_idx;
                            w_wr_en    = 4'b1111;
                            w_word_idx = r_word_idx + PMEM_ADDR_WIDTH'(1);
                            if (w_last) begin
                                w_state = c_ST_CHECK;
                            end
                        end
                    endcase
                end
            end
            c_ST_CHECK: begin
                if (bus.rx_valid) begin
                    w_state = (bus.rx_data == r_xor) ? c_ST_RUN : c_ST_ERR;
                end
            end
            default: begin
                w_state = c_ST_IDLE;
            end
        endcase

        // Inter-byte silence watchdog, only meaningful inside a frame
        if (w_in_frame && !bus.rx_valid) begin
            if (r_timer == c_TMO_LAST) begin
                w_state = c_ST_ERR;
            end else begin
                w_timer = r_timer + c_TW'(1);
            end
        end
    end

    always_comb begin
        w_cpu_rst = (w_state != c_ST_RUN);
        w_busy    = (w_state inside {c_ST_LEN_LO, c_ST_LEN_HI, c_ST_DATA, c_ST_CHECK});
        w_err     = (w_state == c_ST_ERR);
    end

    assign bus.pmem_wr_addr   = r_wr_addr;
    assign bus.pmem_wr_data   = r_wr_data;
    assign bus.pmem_byte_w_en = r_wr_en;
    assign bus.cpu_rst        = r_cpu_rst;
    assign bus.load_busy      = r_busy;
    assign bus.load_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pmem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pmem_loader                                                 |
// | Brief   : Table vectors, corner sequences and random frames for the      |
// |           program loader against a frame-level reference model.         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_pmem_loader;

    localparam int AW    = 12;
    localparam int TMO   = 40;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] byte_q_t[$];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        string        name;
        int           n;
        logic [127:0] frame;
        logic         cpu_rst;
        logic         err;
        int           nwr;
    } vec_t;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    pmem_loader_if #(.PMEM_ADDR_WIDTH(AW)) bus ();

    pmem_loader #(
        .PMEM_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int  n_chk = 0;
    int  n_err = 0;
    int  bad_strobe = 0;
    wr_t wr_log[$];
    wr_t exp_q[$];
    logic m_cpu_rst;
    logic m_err;

    always @(negedge sysclk) begin
        if (bus.pmem_byte_w_en != 4'b0000) begin
            wr_log.push_back('{addr: bus.pmem_wr_addr, data: bus.pmem_wr_data});
            if (bus.pmem_byte_w_en != 4'b1111) bad_strobe++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: find the start byte, slice out words, compare checksum
    task automatic run_model(input byte_q_t q);
        int   i;
        int   cnt;
        int   base;
        logic [7:0] x;
        exp_q.delete();
        m_cpu_rst = 1'b1;
        m_err     = 1'b0;
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        if (i + 2 >= q.size()) return;
        cnt = int'({q[i+2], q[i+1]});
        if (cnt > DEPTH) begin
            m_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < cnt; w++) begin
            base = i + 3 + 4 * w;
            exp_q.push_back('{addr: AW'(w), data: {q[base+3], q[base+2], q[base+1], q[base]}});
            x = x ^ q[base] ^ q[base+1] ^ q[base+2] ^ q[base+3];
        end
        if (q[i + 3 + 4 * cnt] == x) m_cpu_rst = 1'b0;
        else                         m_err     = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        tick(gap);
    endtask

    task automatic send_q(input byte_q_t q, input int max_gap);
        foreach (q[k]) send_byte(q[k], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        wr_log.delete();
    endtask

    task automatic check_writes(input string name);
        check({name, "_nwr"}, 64'(wr_log.size()), 64'(exp_q.size()));
        if (wr_log.size() == exp_q.size())
            foreach (exp_q[k]) check({name, "_wr"}, 64'(wr_log[k]), 64'(exp_q[k]));
    endtask

    vec_t    vecs[8];
    byte_q_t q;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{"good",      12, 128'(96'hA5_02_00_13_00_00_00_93_00_10_00_90), 1'b0, 1'b0, 2};
        vecs[1] = '{"badchk",    12, 128'(96'hA5_02_00_13_00_00_00_93_00_10_00_80), 1'b1, 1'b1, 2};
        vecs[2] = '{"empty",      4, 128'(32'hA5_00_00_00),                          1'b0, 1'b0, 0};
        vecs[3] = '{"empty_bad",  4, 128'(32'hA5_00_00_01),                          1'b1, 1'b1, 0};
        vecs[4] = '{"too_long",   3, 128'(24'hA5_01_10),                             1'b1, 1'b1, 0};
        vecs[5] = '{"garbage",   10, 128'(80'h11_22_A5_01_00_78_56_34_12_08),        1'b0, 1'b0, 1};
        vecs[6] = '{"a5_payload", 8, 128'(64'hA5_01_00_A5_A5_A5_A5_00),              1'b0, 1'b0, 1};
        vecs[7] = '{"no_sof",     3, 128'(24'h00_FF_5A),                             1'b1, 1'b0, 0};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        tick(3);
        check("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        check("rst_busy",    64'(bus.load_busy), 64'd0);
        check("rst_err",     64'(bus.load_err), 64'd0);
        check("rst_wen",     64'(bus.pmem_byte_w_en), 64'd0);
        check("rst_addr",    64'(bus.pmem_wr_addr), 64'd0);
        check("rst_data",    64'(bus.pmem_wr_data), 64'd0);

        // Table vectors, alternating sparse and back-to-back delivery
        for (int v = 0; v < 8; v++) begin
            do_reset();
            q.delete();
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].frame[8*(vecs[v].n-1-i) +: 8]);
            run_model(q);
            send_q(q, (v % 2 == 1) ? 0 : 3);
            tick(3);
            check({vecs[v].name, "_cpu_rst"}, 64'(bus.cpu_rst), 64'(vecs[v].cpu_rst));
            check({vecs[v].name, "_err"},     64'(bus.load_err), 64'(vecs[v].err));
            check({vecs[v].name, "_busy"},    64'(bus.load_busy), 64'd0);
            check({vecs[v].name, "_tblnwr"},  64'(wr_log.size()), 64'(vecs[v].nwr));
            check_writes(vecs[v].name);
        end

        // Error cleared by next frame start, busy raised
        send_byte(8'hA5, 0);
        check("err_clear_on_sof", 64'(bus.load_err), 64'd0);
        check("busy_on_sof",      64'(bus.load_busy), 64'd1);
        check("cpu_rst_in_frame", 64'(bus.cpu_rst), 64'd1);

        // Reload from RUN re-asserts core reset the next cycle
        do_reset();
        q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q(q, 0);
        check("run_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        send_byte(8'h3C, 2);
        check("run_ignores", 64'(bus.cpu_rst), 64'd0);
        send_byte(8'hA5, 0);
        check("reload_cpu_rst", 64'(bus.cpu_rst), 64'd1);

        // Timeout mid-frame: one word written, then silence
        do_reset();
        q = '{8'hA5, 8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55};
        send_q(q, 0);
        tick(TMO - 3);
        check("tmo_early_err",  64'(bus.load_err), 64'd0);
        check("tmo_early_busy", 64'(bus.load_busy), 64'd1);
        tick(5);
        check("tmo_err",     64'(bus.load_err), 64'd1);
        check("tmo_busy",    64'(bus.load_busy), 64'd0);
        check("tmo_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        exp_q.delete();
        exp_q.push_back('{addr: AW'(0), data: 32'hDEADBEEF});
        check_writes("tmo");

        // Reset mid-word: no strobe for the partial word, then a clean reload
        do_reset();
        q = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_q(q, 1);
        tick(2);
        check("midrst_pre_nwr", 64'(wr_log.size()), 64'd1);
        rst = 1'b1;
        tick(1);
        check("midrst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        check("midrst_busy",    64'(bus.load_busy), 64'd0);
        check("midrst_addr",    64'(bus.pmem_wr_addr), 64'd0);
        rst = 1'b0;
        tick(4);
        check("midrst_post_nwr", 64'(wr_log.size()), 64'd1);
        wr_log.delete();
        q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        run_model(q);
        send_q(q, 0);
        tick(2);
        check("midrst_reload_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        check_writes("midrst_reload");

        // Random frames chained without reset, half with a corrupted checksum
        for (int f = 0; f < 10; f++) begin
            int         cnt;
            logic [7:0] x;
            logic [7:0] b;
            cnt = $urandom_range(1, 6);
            x   = 8'h00;
            q   = '{8'hA5, 8'(cnt), 8'h00};
            for (int i = 0; i < 4 * cnt; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                x ^= b;
            end
            q.push_back(($urandom_range(0, 1) == 1) ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
            run_model(q);
            wr_log.delete();
            send_q(q, (f % 3 == 0) ? 0 : 3);
            tick(2);
            check("rnd_cpu_rst", 64'(bus.cpu_rst), 64'(m_cpu_rst));
            check("rnd_err",     64'(bus.load_err), 64'(m_err));
            check_writes("rnd");
        end

        // Full-depth image: last write at all-ones, no wrap
        begin
            logic [7:0] x;
            logic [7:0] b;
            int         bad;
            do_reset();
            x = 8'h00;
            q = '{8'hA5, 8'h00, 8'h10};
            for (int i = 0; i < 4 * DEPTH; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                x ^= b;
            end
            q.push_back(x);
            run_model(q);
            send_q(q, 0);
            tick(3);
            check("fill_cpu_rst", 64'(bus.cpu_rst), 64'd0);
            check("fill_nwr", 64'(wr_log.size()), 64'(DEPTH));
            bad = 0;
            if (wr_log.size() == exp_q.size())
                foreach (exp_q[k]) if (wr_log[k] !== exp_q[k]) bad++;
            check("fill_words", 64'(bad), 64'd0);
            if (wr_log.size() > 0)
                check("fill_last_addr", 64'(wr_log[wr_log.size()-1].addr), 64'(DEPTH - 1));
        end

        check("strobe_shape", 64'(bad_strobe), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
